spart_io_master: RTL and testbench

Initiator side of the SPART memory-mapped IO port. Accepts a byte stream to transmit and produces a byte stream of received characters, converting both into valid/ready read and write transactions on the SPART cache-interface port. It polls the SPART status word, reads RX data when available, and writes TX data when the transmitter is ready. It sits between a byte-level client (console logic, test sequencer) and the SPART top level.

---
 rtl/spart_io_master.sv | 186 ++++++++++++++++++
 tb/tb_spart_io_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_io_master.sv
// spart_io_master: polls the SPART status word and turns a client byte stream into
// SPART valid/ready read/write transactions (RX reads into rx_data, TX writes from a FIFO).
module spart_io_master #(
  parameter int TX_DEPTH = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        io_valid_data,
  output logic        io_rw_data,
  output logic [27:0] mem_addr,
  output logic [31:0] io_wr_data,
  input  logic        io_ready_data,
  input  logic [31:0] io_rd_data,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clear_err
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [27:0]   ADDR_DATA = 28'h800_0000;
  localparam logic [27:0]   ADDR_STAT = 28'h800_0001;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(TX_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    STAT_REQ,
    RX_REQ,
    TX_REQ,
    GAP
  } state_t;

  state_t state, state_nx;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;
  logic          fifo_empty, push, pop;

  logic          gap_idle, gap_idle_nx;
  logic          stat_rx, stat_tx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic          valid_nx, rw_nx;
  logic [27:0]   addr_nx;
  logic [31:0]   wdata_nx;
  logic          load_rx, set_err, latch_stat;

  logic unused_rd_bits;
  assign unused_rd_bits = ^io_rd_data[31:8];

  assign fifo_empty = (fifo_count == '0);
  assign tx_ready   = (fifo_count != FIFO_FULL);
  assign push       = tx_valid && tx_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gap_idle      <= 1'b0;
      stat_rx       <= 1'b0;
      stat_tx       <= 1'b0;
      wait_cnt      <= '0;
      io_valid_data <= 1'b0;
      io_rw_data    <= 1'b0;
      mem_addr      <= '0;
      io_wr_data    <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      gap_idle      <= gap_idle_nx;
      wait_cnt      <= wait_nx;
      io_valid_data <= valid_nx;
      io_rw_data    <= rw_nx;
      mem_addr      <= addr_nx;
      io_wr_data    <= wdata_nx;
      if (latch_stat) begin
        stat_rx <= io_rd_data[0];
        stat_tx <= io_rd_data[1];
      end
      // A load can never coincide with a consume because RX_REQ needs rx_valid low.
      if (load_rx) begin
        rx_data  <= io_rd_data[7:0];
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (set_err)        timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

  // Next-state logic also computes the registered request bus for the following cycle.
  always_comb begin
    state_nx    = state;
    gap_idle_nx = gap_idle;
    wait_nx     = wait_cnt;
    valid_nx    = 1'b0;
    rw_nx       = 1'b0;
    addr_nx     = '0;
    wdata_nx    = '0;
    pop         = 1'b0;
    load_rx     = 1'b0;
    set_err     = 1'b0;
    latch_stat  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_valid || !fifo_empty) begin
          state_nx = STAT_REQ;
          valid_nx = 1'b1;
          addr_nx  = ADDR_STAT;
          wait_nx  = '0;
        end
      end
      STAT_REQ, RX_REQ, TX_REQ: begin
        if (io_ready_data) begin
          state_nx    = GAP;
          gap_idle_nx = (state != STAT_REQ);
          latch_stat  = (state == STAT_REQ);
          load_rx     = (state == RX_REQ);
          pop         = (state == TX_REQ);
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx    = GAP;
          gap_idle_nx = 1'b1;
          set_err     = 1'b1;
        end else begin
          valid_nx = io_valid_data;
          rw_nx    = io_rw_data;
          addr_nx  = mem_addr;
          wdata_nx = io_wr_data;
          wait_nx  = wait_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_idle) begin
          state_nx = IDLE;
        end else if (stat_rx && !rx_valid) begin
          state_nx = RX_REQ;
          valid_nx = 1'b1;
          addr_nx  = ADDR_DATA;
          wait_nx  = '0;
        end else if (stat_tx && !fifo_empty) begin
          state_nx = TX_REQ;
          valid_nx = 1'b1;
          rw_nx    = 1'b1;
          addr_nx  = ADDR_DATA;
          wdata_nx = {24'd0, fifo_mem[rd_ptr]};
          wait_nx  = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spart_io_master.sv
// Scoreboard bench for spart_io_master: a responder model answers requests, and a
// negedge monitor checks data transactions and consumed RX bytes against queued expectations.
module tb_spart_io_master;

  localparam int TIMEOUT = 8;
  localparam logic [27:0] ADDR_DATA = 28'h800_0000;
  localparam logic [27:0] ADDR_STAT = 28'h800_0001;

  logic        clk, rst;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        io_valid_data, io_rw_data;
  logic [27:0] mem_addr;
  logic [31:0] io_wr_data;
  logic        io_ready_data;
  logic [31:0] io_rd_data;
  logic        busy, timeout_err, clear_err;

  logic        resp_stat, resp_data;
  logic [31:0] status_word, rx_word;

  int checks = 0;
  int errors = 0;
  logic [60:0] exp_q [$];
  logic [7:0]  rx_q  [$];
  logic [60:0] exp_item;

  int cyc = 0;
  int last_stat_cyc = -100;
  int vcnt = 0;
  int run_len = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [60:0] prev_bus = '0;

  spart_io_master #(.TX_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .io_valid_data(io_valid_data), .io_rw_data(io_rw_data), .mem_addr(mem_addr),
    .io_wr_data(io_wr_data), .io_ready_data(io_ready_data), .io_rd_data(io_rd_data),
    .busy(busy), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bit done = 1'b0;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (tx_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    checkOutput("push_accepted", done, 1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  task automatic pulseRxReady();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  // Responder: completes a request on its 2nd valid cycle when enabled for that address.
  always begin
    @(posedge clk); #1;
    if (rst || !io_valid_data) begin
      vcnt          = 0;
      io_ready_data = 1'b0;
      io_rd_data    = '0;
    end else begin
      vcnt++;
      if (vcnt == 2 && ((mem_addr == ADDR_STAT) ? resp_stat : resp_data)) begin
        io_ready_data = 1'b1;
        io_rd_data    = (mem_addr == ADDR_STAT) ? status_word : rx_word;
      end else begin
        io_ready_data = 1'b0;
        io_rd_data    = '0;
      end
    end
  end

  // Monitor: bus protocol, data-transaction scoreboard and RX byte scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      run_len    = 0;
    end else begin
      cyc++;
      if (!io_valid_data)
        checkOutput("idle_bus_zero", {io_rw_data, mem_addr, io_wr_data}, 0);
      if (prev_valid && !prev_ready && io_valid_data)
        checkOutput("req_hold", {io_rw_data, mem_addr, io_wr_data}, prev_bus);
      if (prev_valid && prev_ready)
        checkOutput("gap_after_ready", io_valid_data, 0);
      if (prev_valid && !prev_ready && !io_valid_data) begin
        checkOutput("timeout_len", run_len, TIMEOUT);
        checkOutput("timeout_flag_set", timeout_err, 1);
      end
      if (io_valid_data && io_ready_data) begin
        if (mem_addr == ADDR_STAT) begin
          checkOutput("stat_read_fmt", {io_rw_data, io_wr_data}, 0);
          last_stat_cyc = cyc;
        end else begin
          checkOutput("stat_to_data", cyc - last_stat_cyc, 3);
          if (!io_rw_data) checkOutput("rx_collision", rx_valid && rx_ready, 0);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_data_txn", {io_rw_data, mem_addr, io_wr_data}, 0);
          end else begin
            exp_item = exp_q.pop_front();
            checkOutput("data_txn", {io_rw_data, mem_addr, io_wr_data}, exp_item);
          end
        end
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) checkOutput("unexpected_rx", rx_data, 0);
        else checkOutput("rx_byte", rx_data, rx_q.pop_front());
      end
      run_len    = (io_valid_data && prev_valid && !prev_ready) ? run_len + 1 : (io_valid_data ? 1 : 0);
      prev_valid = io_valid_data;
      prev_ready = io_ready_data;
      prev_bus   = {io_rw_data, mem_addr, io_wr_data};
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc;
    bit seen;
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clear_err = 1'b0;
    resp_stat = 1'b1; resp_data = 1'b1; status_word = 32'h0; rx_word = 32'h0;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bus", {io_valid_data, io_rw_data, mem_addr, io_wr_data}, 0);
    checkOutput("rst_rx", {rx_valid, rx_data}, 0);
    checkOutput("rst_flags", {busy, timeout_err}, 0);
    checkOutput("rst_tx_ready", tx_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("first_cycle_idle", io_valid_data, 0);
    @(negedge clk);
    checkOutput("first_stat_req", {io_valid_data, busy, mem_addr}, {1'b1, 1'b1, ADDR_STAT});

    $display("[TB] single TX byte");
    @(posedge clk); #1 status_word = 32'h2;
    exp_q.push_back({1'b1, ADDR_DATA, 32'h0000_0041});
    applyStimulus(8'h41);
    waitDrain(200);
    repeat (12) @(negedge clk);
    checkOutput("tx_ready_after_pop", tx_ready, 1);

    $display("[TB] RX priority over TX");
    @(posedge clk); #1 status_word = 32'h0;
    repeat (10) @(negedge clk);
    exp_q.push_back({1'b0, ADDR_DATA, 32'h0});
    exp_q.push_back({1'b1, ADDR_DATA, 32'h0000_0042});
    rx_q.push_back(8'h5A);
    applyStimulus(8'h42);
    repeat (10) @(negedge clk);
    checkOutput("byte_queued", exp_q.size(), 2);
    @(posedge clk); #1;
    rx_word     = 32'h0000_005A;
    status_word = 32'h3;
    waitDrain(200);
    repeat (3) @(negedge clk);
    checkOutput("rx_loaded", {rx_valid, rx_data}, {1'b1, 8'h5A});

    $display("[TB] RX backpressure");
    @(posedge clk); #1 status_word = 32'h1;
    repeat (3) @(negedge clk);
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io_valid_data) vc++;
    end
    checkOutput("no_poll_while_full", vc, 0);
    rx_word = 32'h0000_0077;
    exp_q.push_back({1'b0, ADDR_DATA, 32'h0});
    rx_q.push_back(8'h77);
    pulseRxReady();
    waitDrain(200);
    repeat (3) @(negedge clk);
    checkOutput("rx_reloaded", {rx_valid, rx_data}, {1'b1, 8'h77});
    @(posedge clk); #1 status_word = 32'h0;
    repeat (3) @(negedge clk);
    pulseRxReady();
    @(negedge clk);
    checkOutput("rx_consumed", rx_valid, 0);

    $display("[TB] timeout and retry");
    @(posedge clk); #1;
    status_word = 32'h2;
    resp_data   = 1'b0;
    exp_q.push_back({1'b1, ADDR_DATA, 32'h0000_0055});
    applyStimulus(8'h55);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (timeout_err) seen = 1'b1;
    end
    checkOutput("timeout_err_seen", seen, 1);
    repeat (30) @(negedge clk);
    checkOutput("byte_retained", exp_q.size(), 1);
    @(posedge clk); #1 resp_data = 1'b1;
    waitDrain(200);
    @(negedge clk);
    checkOutput("timeout_err_sticky", timeout_err, 1);
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    @(negedge clk);
    checkOutput("timeout_err_cleared", timeout_err, 0);

    $display("[TB] FIFO full and drain order");
    @(posedge clk); #1 status_word = 32'h0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, ADDR_DATA, 24'd0, 8'(8'h10 + i)});
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h10 + i));
    @(negedge clk);
    checkOutput("full_after_4", tx_ready, 0);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h14;
    repeat (6) @(negedge clk);
    checkOutput("fifth_held", {tx_ready, 3'd0, exp_q.size()}, {1'b0, 3'd0, 32'd5});
    @(posedge clk); #1 status_word = 32'h2;
    applyStimulus(8'h14);
    waitDrain(400);
    repeat (5) @(negedge clk);
    checkOutput("tx_ready_restored", tx_ready, 1);

    repeat (10) @(negedge clk);
    checkOutput("rx_queue_empty", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
